// File: rtl/m6809_eclk_waitgen.sv
// m6809_eclk_waitgen: E/Q quadrature clock generator with programmable
// per-channel wait states, sys_mrdy stretching with timeout, and
// E-qualified chip selects for the FExx I/O page (6809E mode).
//
// Parameters:
//   DIV  clkin cycles per quadrant (1..16)
//   NCS  number of chip selects (1..8); select i decodes adr == i
//   WSW  width of each per-channel wait-state field
//   TMO  maximum sys_mrdy stretch in quadrants (1..255)
//
// Ports:
//   clkin       in   board clock
//   rst_b       in   asynchronous active-low reset
//   decodeFE_b  in   active-low FExx page decode
//   adr         in   CPU address bits [7:5]
//   sys_mrdy    in   expansion memory-ready, low requests a stretch
//   ws_cfg      in   wait states for channel i in [i*WSW +: WSW]
//   eclk        out  CPU E clock (registered)
//   qclk        out  CPU Q clock (registered)
//   cs_b        out  active-low chip selects, combinational from eclk
//   stretching  out  high during every repeated P3 quadrant
//   mrdy_tmo    out  one-cycle pulse when a sys_mrdy stretch is cut off
module m6809_eclk_waitgen #(
  parameter int unsigned DIV = 1,
  parameter int unsigned NCS = 4,
  parameter int unsigned WSW = 2,
  parameter int unsigned TMO = 15
) (
  input  logic               clkin,
  input  logic               rst_b,
  input  logic               decodeFE_b,
  input  logic [2:0]         adr,
  input  logic               sys_mrdy,
  input  logic [NCS*WSW-1:0] ws_cfg,
  output logic               eclk,
  output logic               qclk,
  output logic [NCS-1:0]     cs_b,
  output logic               stretching,
  output logic               mrdy_tmo
);

  localparam int unsigned QW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW = 8;

  // State encoding equals the {E,Q} pair of each quadrant.
  localparam logic [1:0] P0 = 2'b00;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b11;
  localparam logic [1:0] P3 = 2'b10;

  logic [1:0]     state_q, state_d;
  logic [QW-1:0]  qcnt_q, qcnt_d;
  logic [WSW-1:0] wscnt_q, wscnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           eclk_q, eclk_d;
  logic           qclk_q, qclk_d;
  logic           stretching_q, stretching_d;
  logic           mrdy_tmo_q, mrdy_tmo_d;

  logic [NCS-1:0] hit;
  logic [WSW-1:0] ws_sel;
  logic           q_end;

  // Channel decode and wait-state field of the hit channel.
  always_comb begin
    hit    = '0;
    ws_sel = '0;
    for (int i = 0; i < NCS; i++) begin
      if (!decodeFE_b && (adr == 3'(i))) begin
        hit[i] = 1'b1;
        ws_sel = ws_cfg[i*WSW +: WSW];
      end
    end
  end

  assign q_end = (qcnt_q == QW'(DIV - 1));

  // Quadrant sequencing; P3 repeats for wait states first, then sys_mrdy.
  always_comb begin
    state_d      = state_q;
    qcnt_d       = qcnt_q;
    wscnt_d      = wscnt_q;
    tcnt_d       = tcnt_q;
    stretching_d = stretching_q;
    mrdy_tmo_d   = 1'b0;

    if (!q_end) begin
      qcnt_d = qcnt_q + QW'(1);
    end else begin
      qcnt_d = '0;
      case (state_q)
        P0: state_d = P1;
        P1: state_d = P2;
        P2: begin
          state_d      = P3;
          tcnt_d       = '0;
          stretching_d = 1'b0;
          if (!decodeFE_b) wscnt_d = ws_sel;
        end
        P3: begin
          if (wscnt_q != '0) begin
            wscnt_d      = wscnt_q - WSW'(1);
            stretching_d = 1'b1;
          end else if (!sys_mrdy && (tcnt_q < TW'(TMO))) begin
            tcnt_d       = tcnt_q + TW'(1);
            stretching_d = 1'b1;
          end else begin
            mrdy_tmo_d   = !sys_mrdy;
            state_d      = P0;
            stretching_d = 1'b0;
          end
        end
        default: state_d = P0;
      endcase
    end

    eclk_d = (state_d == P2) || (state_d == P3);
    qclk_d = (state_d == P1) || (state_d == P2);
  end

  always_ff @(posedge clkin or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= P0;
      qcnt_q       <= '0;
      wscnt_q      <= '0;
      tcnt_q       <= '0;
      eclk_q       <= 1'b0;
      qclk_q       <= 1'b0;
      stretching_q <= 1'b0;
      mrdy_tmo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      wscnt_q      <= wscnt_d;
      tcnt_q       <= tcnt_d;
      eclk_q       <= eclk_d;
      qclk_q       <= qclk_d;
      stretching_q <= stretching_d;
      mrdy_tmo_q   <= mrdy_tmo_d;
    end
  end

  assign eclk       = eclk_q;
  assign qclk       = qclk_q;
  assign stretching = stretching_q;
  assign mrdy_tmo   = mrdy_tmo_q;
  // Selects follow E, so they drop asynchronously with reset.
  assign cs_b       = ~(hit & {NCS{eclk_q}});

endmodule
